mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter and miss sequencer that shares one BRAM (`blk_mem_gen_0`, 1-cycle read latency) between the instruction-cache and data-cache miss paths. It accepts one outstanding miss request per cache and grants the BRAM round-robin. For a D-side miss it runs the dirty-victim writeback and then the line refill as one atomic sequence. It then returns refill data with a single-cycle acknowledge that the core uses to release its stall.

## Interface
Parameters:
- `ADDR_W`, 10, BRAM word address width.
- `DATA_W`, 32, data word width.

Ports:
- `clka`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `i_req`  in  1  I-cache miss request; held until `i_ack`.
- `i_addr`  in  ADDR_W  I-side refill word address.
- `i_rdata`  out  DATA_W  I-side refill data; valid while `i_ack`.
- `i_ack`  out  1  one-cycle completion pulse to the I-cache.
- `d_req`  in  1  D-cache miss request; held until `d_ack`.
- `d_wb`  in  1  a dirty victim must be written back first.
- `d_wb_addr`  in  ADDR_W  victim address (`{ctag,index}`).
- `d_wb_data`  in  DATA_W  victim data block.
- `d_rd`  in  1  a refill read is needed (0 for store-miss/flush-only).
- `d_addr`  in  ADDR_W  D-side refill word address.
- `d_rdata`  out  DATA_W  D-side refill data; valid while `d_ack`.
- `d_ack`  out  1  one-cycle completion pulse to the D-cache.
- `m_en`  out  1  BRAM enable.
- `m_we`  out  1  BRAM write enable.
- `m_addr`  out  ADDR_W  BRAM address.
- `m_wdata`  out  DATA_W  BRAM write data.
- `m_rdata`  in  DATA_W  BRAM read data; valid one cycle after a read is issued.
- `busy`  out  1  high in every state except IDLE.
- `grant`  out  1  current owner, 0 = I and 1 = D; meaningful only while `busy`.

## Operation
- States: IDLE, WB, RD, WAIT, DONE. `owner` register (0 = I, 1 = D) and `last` register (the last served side).
- IDLE: if exactly one request is high, grant it. If both are high, grant the side opposite to `last`. On grant, set `owner` and `last`, and latch that requester's addresses, `d_wb`, `d_rd` and `d_wb_data`.
- Next state after grant:
  - I granted: RD.
  - D granted with `d_wb=1`: WB.
  - D granted with `d_wb=0, d_rd=1`: RD.
  - D granted with `d_wb=0, d_rd=0`: DONE (no BRAM access).
- WB: `m_en=1`, `m_we=1`, `m_addr` = latched wb address, `m_wdata` = latched wb data. Next state is RD if latched `d_rd=1`, else DONE.
- RD: `m_en=1`, `m_we=0`, `m_addr` = latched refill address. Next state WAIT.
- WAIT: `m_en=0`. Capture `m_rdata` into the owner's rdata register. Next state DONE.
- DONE: the owner's ack is high for exactly this cycle. Next state IDLE. Requests are not sampled in DONE.
- `m_*` outputs decode combinationally from state and latched operands. They are 0 in IDLE, WAIT and DONE.
- `i_rdata` / `d_rdata` are registers. They change only on a WAIT capture for their own side and otherwise hold their last value.
- Requester contract: the request and its operands stay stable from assertion until the ack cycle. The request is deasserted in the cycle after ack. The arbiter latches operands at grant, so changes after grant are ignored.
- Reset values: state IDLE, `last=1` (I wins the first tie), `owner=0`, `i_rdata=d_rdata=0`. All outputs are 0: `i_ack`, `d_ack`, `m_en`, `m_we`, `m_addr`, `m_wdata`, `busy`, `grant`.

## Timing
- Cycle 0 is the IDLE cycle in which the request is sampled.
- Latency from cycle 0 to the ack cycle:
  - I read: 3 (RD@1, WAIT@2, DONE@3).
  - D wb+rd: 4 (WB@1, RD@2, WAIT@3, DONE@4).
  - D rd-only: 3.
  - D wb-only: 2.
  - D no-op: 1.
- Back-to-back: a new grant is possible in the cycle after DONE. The minimum request-to-request spacing is latency + 1.
- A losing requester waits in IDLE arbitration. A starved side is guaranteed service right after the current transaction, because round-robin with `last` ensures it.
- `rst` asserted in any state: IDLE from the next cycle, with no ack issued and all `m_*` at 0 from that cycle. A BRAM write already issued in WB is not undone. Requesters re-issue after reset.
- A request that rises during a transaction is served after DONE, never preempting the transaction.

## Test plan
- I-only: `i_req=1`, `i_addr=0x005`, BRAM[5]=0xDEADBEEF -> `m_en` read of 0x005 at cycle 1; `i_ack=1` with `i_rdata=0xDEADBEEF` at cycle 3; `d_ack` stays 0.
- D wb+rd: `d_wb=1`, `d_wb_addr=0x081`, `d_wb_data=0x12345678`, `d_rd=1`, `d_addr=0x101`, BRAM[0x101]=0xCAFEF00D -> write of 0x081 at cycle 1, read of 0x101 at cycle 2, `d_ack` with `d_rdata=0xCAFEF00D` at cycle 4; readback of 0x081 returns 0x12345678.
- Tie after reset: `i_req` and `d_req` both held -> I served first (ack cycle 3), D granted at cycle 4; repeat the tie -> I then D again (strict alternation).
- D wb-only: `d_wb=1`, `d_rd=0` -> a single write at cycle 1, `d_ack` at cycle 2, `d_rdata` unchanged from its prior value.
- Reset mid-op: assert `rst` in the WAIT cycle of a D refill -> no `d_ack`; next cycle `busy=0`, `m_en=0`; a re-issued request then completes normally.
- Operand stability: change `d_addr` the cycle after grant -> the read still uses the originally latched address.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between I-cache and D-cache miss paths.
// A D-side miss runs victim writeback then refill as one atomic sequence.
module mem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clka,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_wb,
    input  logic [ADDR_W-1:0] d_wb_addr,
    input  logic [DATA_W-1:0] d_wb_data,
    input  logic              d_rd,
    input  logic [ADDR_W-1:0] d_addr,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy,
    output logic              grant
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WB   = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              rd_need_q, rd_need_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              sel_dside;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        rd_need_d = rd_need_q;
        rd_addr_d = rd_addr_q;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        sel_dside = 1'b0;
        case (state_q)
            S_IDLE: begin
                // On a tie the side that was not served last wins.
                sel_dside = d_req && (!i_req || !last_q);
                if (i_req || d_req) begin
                    owner_d = sel_dside;
                    last_d  = sel_dside;
                    if (sel_dside) begin
                        rd_addr_d = d_addr;
                        wb_addr_d = d_wb_addr;
                        wb_data_d = d_wb_data;
                        rd_need_d = d_rd;
                        if (d_wb)
                            state_d = S_WB;
                        else if (d_rd)
                            state_d = S_RD;
                        else
                            state_d = S_DONE;
                    end else begin
                        rd_addr_d = i_addr;
                        rd_need_d = 1'b1;
                        state_d   = S_RD;
                    end
                end
            end
            S_WB:   state_d = rd_need_q ? S_RD : S_DONE;
            S_RD:   state_d = S_WAIT;
            S_WAIT: begin
                if (owner_q)
                    d_rdata_d = m_rdata;
                else
                    i_rdata_d = m_rdata;
                state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // Latched operands need no reset: they are only read after a fresh grant.
    always_ff @(posedge clka) begin
        rd_need_q <= rd_need_d;
        rd_addr_q <= rd_addr_d;
        wb_addr_q <= wb_addr_d;
        wb_data_q <= wb_data_d;
    end

    always_comb begin
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        case (state_q)
            S_WB: begin
                m_en    = 1'b1;
                m_we    = 1'b1;
                m_addr  = wb_addr_q;
                m_wdata = wb_data_q;
            end
            S_RD: begin
                m_en   = 1'b1;
                m_addr = rd_addr_q;
            end
            default: ;
        endcase
    end

    assign busy    = (state_q != S_IDLE);
    assign grant   = busy && owner_q;
    assign i_ack   = (state_q == S_DONE) && !owner_q;
    assign d_ack   = (state_q == S_DONE) && owner_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural 1-cycle-latency BRAM model.
module tb_mem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clka = 1'b0;
    logic          rst;
    logic          i_req, d_req, d_wb, d_rd;
    logic [AW-1:0] i_addr, d_wb_addr, d_addr;
    logic [DW-1:0] d_wb_data;
    logic [DW-1:0] i_rdata, d_rdata;
    logic          i_ack, d_ack;
    logic          m_en, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic          busy, grant;

    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    typedef struct packed {
        logic          side;
        logic [DW-1:0] data;
        logic [7:0]    cyc;
    } ack_t;

    ack_t exp_q[$];
    ack_t obs_q[$];
    int   nassert = 0;
    int   nfail   = 0;

    logic          en_log    [0:15];
    logic          we_log    [0:15];
    logic [AW-1:0] addr_log  [0:15];
    logic [DW-1:0] wdata_log [0:15];
    logic          busy_log  [0:15];
    logic          grant_log [0:15];
    logic          dack_log  [0:15];

    always #5 clka = ~clka;

    always @(posedge clka) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (m_en) begin
            if (m_we)
                mem[m_addr] <= m_wdata;
            m_rdata <= mem[m_addr];
        end
    end

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clka(clka), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_wb(d_wb), .d_wb_addr(d_wb_addr), .d_wb_data(d_wb_data),
        .d_rd(d_rd), .d_addr(d_addr), .d_rdata(d_rdata), .d_ack(d_ack),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .busy(busy), .grant(grant)
    );

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(posedge clka);
        #1 pre_we = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clka);
        #1 rst = 1'b0;
    endtask

    // Samples cycles first..last_c mid-cycle; requesters drop their request on ack.
    task automatic run_cycles(input int first, input int last_c);
        ack_t a;
        for (int k = first; k <= last_c; k++) begin
            @(negedge clka);
            en_log[k]    = m_en;
            we_log[k]    = m_we;
            addr_log[k]  = m_addr;
            wdata_log[k] = m_wdata;
            busy_log[k]  = busy;
            grant_log[k] = grant;
            dack_log[k]  = d_ack;
            if (i_ack) begin
                a.side = 1'b0; a.data = i_rdata; a.cyc = 8'(k);
                obs_q.push_back(a);
                i_req = 1'b0;
            end
            if (d_ack) begin
                a.side = 1'b1; a.data = d_rdata; a.cyc = 8'(k);
                obs_q.push_back(a);
                d_req = 1'b0;
            end
        end
    endtask

    function automatic ack_t mk(input logic s, input logic [DW-1:0] d, input int c);
        ack_t a;
        a.side = s; a.data = d; a.cyc = 8'(c);
        return a;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        i_req = 0; d_req = 0; d_wb = 0; d_rd = 0; pre_we = 0;
        i_addr = '0; d_wb_addr = '0; d_addr = '0; d_wb_data = '0; pre_addr = '0; pre_data = '0;
        repeat (2) @(posedge clka);
        #1;
        nassert++;
        if ({i_ack, d_ack, m_en, m_we, busy, grant} !== 6'b0) begin
            nfail++;
            $display("FAIL reset_ctrl: got {i_ack,d_ack,m_en,m_we,busy,grant}=%b, required 000000",
                     {i_ack, d_ack, m_en, m_we, busy, grant});
        end
        nassert++;
        if (m_addr !== '0 || m_wdata !== '0) begin
            nfail++;
            $display("FAIL reset_mbus: got m_addr=%h m_wdata=%h, required 0/0", m_addr, m_wdata);
        end
        nassert++;
        if (i_rdata !== '0 || d_rdata !== '0) begin
            nfail++;
            $display("FAIL reset_rdata: got i_rdata=%h d_rdata=%h, required 0/0", i_rdata, d_rdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_i_only();
        ack_t e, o;
        logic any_dack;
        preload(10'h005, 32'hDEADBEEF);
        exp_q.push_back(mk(1'b0, 32'hDEADBEEF, 3));
        i_addr = 10'h005;
        i_req  = 1'b1;
        run_cycles(0, 6);
        nassert++;
        if (en_log[0] !== 1'b0 || busy_log[0] !== 1'b0) begin
            nfail++;
            $display("FAIL ionly_c0: got en=%b busy=%b, required 0/0", en_log[0], busy_log[0]);
        end
        nassert++;
        if ({en_log[1], we_log[1], busy_log[1], grant_log[1]} !== 4'b1010 || addr_log[1] !== 10'h005) begin
            nfail++;
            $display("FAIL ionly_rd: got en/we/busy/grant=%b addr=%h, required 1010 addr=005",
                     {en_log[1], we_log[1], busy_log[1], grant_log[1]}, addr_log[1]);
        end
        nassert++;
        if (en_log[2] !== 1'b0 || busy_log[4] !== 1'b0) begin
            nfail++;
            $display("FAIL ionly_wait_idle: got en@2=%b busy@4=%b, required 0/0", en_log[2], busy_log[4]);
        end
        any_dack = 1'b0;
        for (int k = 0; k <= 6; k++) any_dack = any_dack | dack_log[k];
        nassert++;
        if (any_dack !== 1'b0) begin
            nfail++;
            $display("FAIL ionly_no_dack: got d_ack seen=%b, required 0", any_dack);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            nassert++;
            if (obs_q.size() == 0) begin
                nfail++;
                $display("FAIL ionly_ack: no ack, required side=%0d data=%h cyc=%0d", e.side, e.data, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    nfail++;
                    $display("FAIL ionly_ack: got side=%0d data=%h cyc=%0d, required side=%0d data=%h cyc=%0d",
                             o.side, o.data, o.cyc, e.side, e.data, e.cyc);
                end
            end
        end
        nassert++;
        if (obs_q.size() != 0) begin
            nfail++;
            $display("FAIL ionly_extra: got %0d extra acks, required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_d_wb_rd();
        ack_t e, o;
        preload(10'h101, 32'hCAFEF00D);
        exp_q.push_back(mk(1'b1, 32'hCAFEF00D, 4));
        d_wb = 1'b1; d_wb_addr = 10'h081; d_wb_data = 32'h12345678;
        d_rd = 1'b1; d_addr = 10'h101; d_req = 1'b1;
        run_cycles(0, 7);
        nassert++;
        if ({en_log[1], we_log[1], grant_log[1]} !== 3'b111 || addr_log[1] !== 10'h081 ||
            wdata_log[1] !== 32'h12345678) begin
            nfail++;
            $display("FAIL dwbrd_wb: got en/we/grant=%b addr=%h wdata=%h, required 111 081 12345678",
                     {en_log[1], we_log[1], grant_log[1]}, addr_log[1], wdata_log[1]);
        end
        nassert++;
        if ({en_log[2], we_log[2]} !== 2'b10 || addr_log[2] !== 10'h101 || en_log[3] !== 1'b0) begin
            nfail++;
            $display("FAIL dwbrd_rd: got en/we=%b addr=%h en@3=%b, required 10 101 0",
                     {en_log[2], we_log[2]}, addr_log[2], en_log[3]);
        end
        // readback of the victim through the I side
        @(posedge clka); #1;
        exp_q.push_back(mk(1'b0, 32'h12345678, 3));
        i_addr = 10'h081; i_req = 1'b1;
        run_cycles(0, 6);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            nassert++;
            if (obs_q.size() == 0) begin
                nfail++;
                $display("FAIL dwbrd_ack: no ack, required side=%0d data=%h cyc=%0d", e.side, e.data, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    nfail++;
                    $display("FAIL dwbrd_ack: got side=%0d data=%h cyc=%0d, required side=%0d data=%h cyc=%0d",
                             o.side, o.data, o.cyc, e.side, e.data, e.cyc);
                end
            end
        end
        nassert++;
        if (obs_q.size() != 0) begin
            nfail++;
            $display("FAIL dwbrd_extra: got %0d extra acks, required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_tie();
        ack_t e, o;
        apply_reset();
        for (int r = 0; r < 3; r++) begin
            @(posedge clka); #1;
            if (r == 2) begin
                // an I-only transaction leaves last=I, so the next tie goes to D
                exp_q.push_back(mk(1'b0, 32'hDEADBEEF, 3));
                i_addr = 10'h005; i_req = 1'b1;
                run_cycles(0, 5);
                @(posedge clka); #1;
                exp_q.push_back(mk(1'b1, 32'hCAFEF00D, 3));
                exp_q.push_back(mk(1'b0, 32'hDEADBEEF, 7));
            end else begin
                exp_q.push_back(mk(1'b0, 32'hDEADBEEF, 3));
                exp_q.push_back(mk(1'b1, 32'hCAFEF00D, 7));
            end
            i_addr = 10'h005; d_wb = 1'b0; d_rd = 1'b1; d_addr = 10'h101;
            i_req = 1'b1; d_req = 1'b1;
            run_cycles(0, 9);
            nassert++;
            if (busy_log[1] !== 1'b1 || grant_log[1] !== (r == 2) || grant_log[5] !== (r != 2)) begin
                nfail++;
                $display("FAIL tie_grant r%0d: got busy@1=%b grant@1=%b grant@5=%b, required 1 %0d %0d",
                         r, busy_log[1], grant_log[1], grant_log[5], (r == 2), (r != 2));
            end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                nassert++;
                if (obs_q.size() == 0) begin
                    nfail++;
                    $display("FAIL tie_ack r%0d: no ack, required side=%0d data=%h cyc=%0d", r, e.side, e.data, e.cyc);
                end else begin
                    o = obs_q.pop_front();
                    if (o !== e) begin
                        nfail++;
                        $display("FAIL tie_ack r%0d: got side=%0d data=%h cyc=%0d, required side=%0d data=%h cyc=%0d",
                                 r, o.side, o.data, o.cyc, e.side, e.data, e.cyc);
                    end
                end
            end
            nassert++;
            if (obs_q.size() != 0) begin
                nfail++;
                $display("FAIL tie_extra r%0d: got %0d extra acks, required 0", r, obs_q.size());
                obs_q.delete();
            end
        end
    endtask

    task automatic test_d_wb_only();
        ack_t e, o;
        logic any_en;
        @(posedge clka); #1;
        exp_q.push_back(mk(1'b1, 32'hCAFEF00D, 2));
        d_wb = 1'b1; d_wb_addr = 10'h0A0; d_wb_data = 32'h55AA55AA; d_rd = 1'b0; d_req = 1'b1;
        run_cycles(0, 5);
        nassert++;
        if ({en_log[1], we_log[1]} !== 2'b11 || addr_log[1] !== 10'h0A0 ||
            wdata_log[1] !== 32'h55AA55AA || en_log[2] !== 1'b0) begin
            nfail++;
            $display("FAIL wbonly_wr: got en/we=%b addr=%h wdata=%h en@2=%b, required 11 0a0 55aa55aa 0",
                     {en_log[1], we_log[1]}, addr_log[1], wdata_log[1], en_log[2]);
        end
        // no-op miss: no BRAM traffic, ack in the cycle after grant
        @(posedge clka); #1;
        exp_q.push_back(mk(1'b1, 32'hCAFEF00D, 1));
        d_wb = 1'b0; d_rd = 1'b0; d_req = 1'b1;
        run_cycles(0, 4);
        any_en = 1'b0;
        for (int k = 0; k <= 4; k++) any_en = any_en | en_log[k];
        nassert++;
        if (any_en !== 1'b0) begin
            nfail++;
            $display("FAIL noop_no_bram: got m_en seen=%b, required 0", any_en);
        end
        @(posedge clka); #1;
        exp_q.push_back(mk(1'b0, 32'h55AA55AA, 3));
        i_addr = 10'h0A0; i_req = 1'b1;
        run_cycles(0, 5);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            nassert++;
            if (obs_q.size() == 0) begin
                nfail++;
                $display("FAIL wbonly_ack: no ack, required side=%0d data=%h cyc=%0d", e.side, e.data, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    nfail++;
                    $display("FAIL wbonly_ack: got side=%0d data=%h cyc=%0d, required side=%0d data=%h cyc=%0d",
                             o.side, o.data, o.cyc, e.side, e.data, e.cyc);
                end
            end
        end
        nassert++;
        if (obs_q.size() != 0) begin
            nfail++;
            $display("FAIL wbonly_extra: got %0d extra acks, required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_reset_mid_op();
        ack_t e, o;
        @(posedge clka); #1;
        d_wb = 1'b0; d_rd = 1'b1; d_addr = 10'h101; d_req = 1'b1;
        @(negedge clka);
        @(negedge clka);
        @(posedge clka); #1;
        rst = 1'b1;
        @(negedge clka);
        nassert++;
        if (busy !== 1'b1 || m_en !== 1'b0 || d_ack !== 1'b0) begin
            nfail++;
            $display("FAIL rstmid_wait: got busy=%b m_en=%b d_ack=%b, required 1 0 0", busy, m_en, d_ack);
        end
        @(posedge clka); #1;
        rst = 1'b0;
        d_req = 1'b0;
        @(negedge clka);
        nassert++;
        if (busy !== 1'b0 || m_en !== 1'b0 || d_ack !== 1'b0 || d_rdata !== '0) begin
            nfail++;
            $display("FAIL rstmid_after: got busy=%b m_en=%b d_ack=%b d_rdata=%h, required 0 0 0 0",
                     busy, m_en, d_ack, d_rdata);
        end
        run_cycles(4, 8);
        nassert++;
        if (obs_q.size() != 0) begin
            nfail++;
            $display("FAIL rstmid_noack: got %0d acks, required 0", obs_q.size());
            obs_q.delete();
        end
        @(posedge clka); #1;
        exp_q.push_back(mk(1'b1, 32'hCAFEF00D, 3));
        d_req = 1'b1;
        run_cycles(0, 6);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            nassert++;
            if (obs_q.size() == 0) begin
                nfail++;
                $display("FAIL rstmid_ack: no ack, required side=%0d data=%h cyc=%0d", e.side, e.data, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    nfail++;
                    $display("FAIL rstmid_ack: got side=%0d data=%h cyc=%0d, required side=%0d data=%h cyc=%0d",
                             o.side, o.data, o.cyc, e.side, e.data, e.cyc);
                end
            end
        end
    endtask

    task automatic test_operand_stability();
        ack_t e, o;
        @(posedge clka); #1;
        exp_q.push_back(mk(1'b1, 32'hCAFEF00D, 3));
        d_wb = 1'b0; d_rd = 1'b1; d_addr = 10'h101; d_req = 1'b1;
        run_cycles(0, 0);
        @(posedge clka); #1;
        d_addr = 10'h005;
        run_cycles(1, 6);
        nassert++;
        if (en_log[1] !== 1'b1 || addr_log[1] !== 10'h101) begin
            nfail++;
            $display("FAIL stable_addr: got en=%b addr=%h, required 1 101", en_log[1], addr_log[1]);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            nassert++;
            if (obs_q.size() == 0) begin
                nfail++;
                $display("FAIL stable_ack: no ack, required side=%0d data=%h cyc=%0d", e.side, e.data, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    nfail++;
                    $display("FAIL stable_ack: got side=%0d data=%h cyc=%0d, required side=%0d data=%h cyc=%0d",
                             o.side, o.data, o.cyc, e.side, e.data, e.cyc);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        ack_t e, o;
        @(posedge clka); #1;
        exp_q.push_back(mk(1'b0, 32'hDEADBEEF, 3));
        i_addr = 10'h005; i_req = 1'b1;
        run_cycles(0, 0);
        @(posedge clka); #1;
        exp_q.push_back(mk(1'b1, 32'h0BADCAFE, 8));
        d_wb = 1'b1; d_wb_addr = 10'h0B0; d_wb_data = 32'h0BADCAFE;
        d_rd = 1'b1; d_addr = 10'h0B0; d_req = 1'b1;
        run_cycles(1, 11);
        nassert++;
        if ({en_log[1], we_log[1]} !== 2'b10 || addr_log[1] !== 10'h005 || grant_log[2] !== 1'b0) begin
            nfail++;
            $display("FAIL b2b_nopreempt: got en/we=%b addr=%h grant@2=%b, required 10 005 0",
                     {en_log[1], we_log[1]}, addr_log[1], grant_log[2]);
        end
        nassert++;
        if ({en_log[5], we_log[5], grant_log[5]} !== 3'b111 || addr_log[5] !== 10'h0B0 ||
            {en_log[6], we_log[6]} !== 2'b10 || addr_log[6] !== 10'h0B0) begin
            nfail++;
            $display("FAIL b2b_dseq: got c5 en/we/grant=%b addr=%h c6 en/we=%b addr=%h, required 111 0b0 10 0b0",
                     {en_log[5], we_log[5], grant_log[5]}, addr_log[5], {en_log[6], we_log[6]}, addr_log[6]);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            nassert++;
            if (obs_q.size() == 0) begin
                nfail++;
                $display("FAIL b2b_ack: no ack, required side=%0d data=%h cyc=%0d", e.side, e.data, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    nfail++;
                    $display("FAIL b2b_ack: got side=%0d data=%h cyc=%0d, required side=%0d data=%h cyc=%0d",
                             o.side, o.data, o.cyc, e.side, e.data, e.cyc);
                end
            end
        end
        nassert++;
        if (obs_q.size() != 0) begin
            nfail++;
            $display("FAIL b2b_extra: got %0d extra acks, required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_i_only();
        test_d_wb_rd();
        test_tie();
        test_d_wb_only();
        test_reset_mid_op();
        test_operand_stability();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
